// File: rtl/bird_pkg.sv
// Shared types and screen constants for the Flappy Bird game sequencer.
package bird_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PLAY  = 2'b01,
        DYING = 2'b10,
        OVER  = 2'b11
    } game_state_t;

    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_SPACE = 8'h2C;

    localparam int Y_MIN = 0;
    localparam int Y_MAX = 479;

    function automatic logic is_flap_key(input logic [7:0] key);
        return (key == KEY_W) || (key == KEY_SPACE);
    endfunction

endpackage

// File: rtl/flap_detect.sv
// Turns the held keycode into a single-frame flap pulse on the press of W or Space.
module flap_detect
    import bird_pkg::*;
(
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    output logic       flap_evt
);

    logic [7:0] prev_key;

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            prev_key <= 8'h00;
        end else begin
            prev_key <= keycode;
        end
    end

    // Both flap keys count as the same button, so sliding from W to Space while held is not a new press.
    assign flap_evt = is_flap_key(keycode) && !is_flap_key(prev_key);

endmodule

// File: rtl/bird_game_ctrl.sv
// Game sequencer: bird vertical physics, IDLE/PLAY/DYING/OVER flow, pipe scroll gating and scoring.
module bird_game_ctrl
    import bird_pkg::*;
#(
    parameter int BIRD_X   = 100,
    parameter int Y_START  = 240,
    parameter int BIRD_S   = 16,
    parameter int GRAVITY  = 1,
    parameter int FLAP_VEL = 8,
    parameter int VEL_MAX  = 8
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic       pipe_hit,
    input  logic       pipe_pass,
    output logic [9:0] BirdX,
    output logic [9:0] BirdY,
    output logic [9:0] BirdS,
    output logic [1:0] game_state,
    output logic       run,
    output logic [7:0] score,
    output logic [7:0] high_score
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_PLAY  = PLAY;
    localparam logic [1:0] ST_DYING = DYING;
    localparam logic [1:0] ST_OVER  = OVER;

    localparam logic signed [10:0] V_FLAP  = 11'(-FLAP_VEL);
    localparam logic signed [10:0] V_GRAV  = 11'(GRAVITY);
    localparam logic signed [10:0] V_MAX   = 11'(VEL_MAX);
    localparam logic signed [10:0] HALF    = 11'(BIRD_S);
    localparam logic signed [10:0] LIM_MIN = 11'(Y_MIN);
    localparam logic signed [10:0] LIM_MAX = 11'(Y_MAX);
    localparam logic [9:0]         Y_TOP   = 10'(Y_MIN + BIRD_S);
    localparam logic [9:0]         Y_FLOOR = 10'(Y_MAX - BIRD_S);
    localparam logic [9:0]         Y_HOME  = 10'(Y_START);

    logic              flap_evt;
    logic [1:0]        state, state_nx;
    logic [9:0]        y, y_nx;
    logic signed [10:0] vel, vel_nx;
    logic [7:0]        score_r, score_nx;
    logic [7:0]        high_r, high_nx;
    logic              run_r;

    logic signed [10:0] y_s, y_sum, vel_grav;
    logic              hit_ground, hit_ceiling, flap_ok;

    flap_detect u_flap (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .keycode   (keycode),
        .flap_evt  (flap_evt)
    );

    // Position advances with the old velocity; the new velocity only affects the next frame.
    assign y_s         = {1'b0, y};
    assign y_sum       = y_s + vel;
    assign vel_grav    = (vel + V_GRAV > V_MAX) ? V_MAX : vel + V_GRAV;
    assign hit_ground  = (y_sum + HALF >= LIM_MAX);
    assign hit_ceiling = (y_sum - HALF < LIM_MIN);

    always_comb begin
        state_nx = state;
        y_nx     = y;
        vel_nx   = vel;
        score_nx = score_r;
        high_nx  = high_r;
        flap_ok  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (flap_evt) begin
                    state_nx = ST_PLAY;
                    score_nx = 8'd0;
                    vel_nx   = V_FLAP;
                end
            end
            ST_PLAY, ST_DYING: begin
                flap_ok = (state == ST_PLAY) && flap_evt;
                if (hit_ground) begin
                    y_nx     = Y_FLOOR;
                    vel_nx   = '0;
                    state_nx = ST_OVER;
                    high_nx  = (score_r > high_r) ? score_r : high_r;
                end else begin
                    if (hit_ceiling) begin
                        y_nx   = Y_TOP;
                        vel_nx = flap_ok ? V_FLAP : '0;
                    end else begin
                        y_nx   = y_sum[9:0];
                        vel_nx = flap_ok ? V_FLAP : vel_grav;
                    end
                    // A pipe strike stops any climb and takes precedence over a pass on the same frame.
                    if (state == ST_PLAY) begin
                        if (pipe_hit) begin
                            state_nx = ST_DYING;
                            if (vel_nx[10]) begin
                                vel_nx = '0;
                            end
                        end else if (pipe_pass && (score_r != 8'hFF)) begin
                            score_nx = score_r + 8'd1;
                        end
                    end
                end
            end
            ST_OVER: begin
                if (flap_evt) begin
                    state_nx = ST_IDLE;
                    y_nx     = Y_HOME;
                    vel_nx   = '0;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state   <= ST_IDLE;
            y       <= Y_HOME;
            vel     <= '0;
            score_r <= 8'd0;
            high_r  <= 8'd0;
            run_r   <= 1'b0;
        end else begin
            state   <= state_nx;
            y       <= y_nx;
            vel     <= vel_nx;
            score_r <= score_nx;
            high_r  <= high_nx;
            run_r   <= (state_nx == ST_PLAY);
        end
    end

    assign BirdX      = 10'(BIRD_X);
    assign BirdS      = 10'(BIRD_S);
    assign BirdY      = y;
    assign game_state = state;
    assign run        = run_r;
    assign score      = score_r;
    assign high_score = high_r;

endmodule

// File: tb/tb_bird_game_ctrl.sv
// Randomized and directed bench for bird_game_ctrl against an integer game model.
module tb_bird_game_ctrl;

    logic       frame_clk = 1'b0;
    logic       Reset;
    logic [7:0] keycode;
    logic       pipe_hit;
    logic       pipe_pass;
    logic [9:0] BirdX, BirdY, BirdS;
    logic [1:0] game_state;
    logic       run;
    logic [7:0] score, high_score;

    int checks = 0;
    int errors = 0;

    bird_game_ctrl dut (
        .frame_clk  (frame_clk),
        .Reset      (Reset),
        .keycode    (keycode),
        .pipe_hit   (pipe_hit),
        .pipe_pass  (pipe_pass),
        .BirdX      (BirdX),
        .BirdY      (BirdY),
        .BirdS      (BirdS),
        .game_state (game_state),
        .run        (run),
        .score      (score),
        .high_score (high_score)
    );

    always #5 frame_clk = ~frame_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Game model: states 0 idle, 1 play, 2 dying, 3 over; plain integers throughout.
    int         m_state, m_y, m_vel, m_score, m_high;
    logic [7:0] m_prev;

    function automatic bit flap_key(input logic [7:0] k);
        return (k == 8'h1A) || (k == 8'h2C);
    endfunction

    task automatic model_reset();
        m_state = 0; m_y = 240; m_vel = 0; m_score = 0; m_high = 0; m_prev = 8'h00;
    endtask

    task automatic model_step(input logic [7:0] k, input logic hit, input logic pass);
        bit flap;
        int y_try, v_try;
        flap = flap_key(k) && !flap_key(m_prev);
        m_prev = k;
        if (m_state == 0) begin
            if (flap) begin m_state = 1; m_score = 0; m_vel = -8; end
        end else if (m_state == 3) begin
            if (flap) begin m_state = 0; m_y = 240; m_vel = 0; end
        end else begin
            if (m_state != 1) flap = 0;
            y_try = m_y + m_vel;
            v_try = flap ? -8 : ((m_vel + 1 > 8) ? 8 : m_vel + 1);
            if (y_try + 16 >= 479) begin
                m_y = 463; m_vel = 0; m_state = 3;
                if (m_score > m_high) m_high = m_score;
            end else begin
                if (y_try - 16 < 0) begin
                    y_try = 16;
                    if (!flap) v_try = 0;
                end
                m_y = y_try; m_vel = v_try;
                if (m_state == 1 && hit) begin
                    m_state = 2;
                    if (m_vel < 0) m_vel = 0;
                end else if (m_state == 1 && pass && m_score < 255) begin
                    m_score++;
                end
            end
        end
    endtask

    task automatic frame(input logic [7:0] k, input logic hit, input logic pass);
        Reset = 1'b0; keycode = k; pipe_hit = hit; pipe_pass = pass;
        @(posedge frame_clk);
        model_step(k, hit, pass);
        #1;
    endtask

    task automatic do_reset(input logic [7:0] k);
        Reset = 1'b1; keycode = k; pipe_hit = 1'b1; pipe_pass = 1'b1;
        @(posedge frame_clk);
        model_reset();
        #1;
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(8'h00);
        checks += 7;
        if (game_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", game_state); end
        if (BirdY !== 10'd240) begin errors++; $display("FAIL reset_y got %0d exp 240", BirdY); end
        if (score !== 8'd0) begin errors++; $display("FAIL reset_score got %0d exp 0", score); end
        if (high_score !== 8'd0) begin errors++; $display("FAIL reset_high got %0d exp 0", high_score); end
        if (run !== 1'b0) begin errors++; $display("FAIL reset_run got %0b exp 0", run); end
        if (BirdX !== 10'd100) begin errors++; $display("FAIL bird_x got %0d exp 100", BirdX); end
        if (BirdS !== 10'd16) begin errors++; $display("FAIL bird_s got %0d exp 16", BirdS); end
    endtask

    task automatic test_first_flap();
        int exp_y[3] = '{232, 225, 219};
        frame(8'h1A, 1'b0, 1'b0);
        checks += 3;
        if (game_state !== 2'd1) begin errors++; $display("FAIL flap_start_state got %0d exp 1", game_state); end
        if (BirdY !== 10'd240) begin errors++; $display("FAIL flap_start_y got %0d exp 240", BirdY); end
        if (run !== 1'b1) begin errors++; $display("FAIL flap_start_run got %0b exp 1", run); end
        for (int i = 0; i < 3; i++) begin
            frame(8'h00, 1'b0, 1'b0);
            checks++;
            if (BirdY !== 10'(exp_y[i]) || run !== 1'b1) begin
                errors++;
                $display("FAIL flap_arc frame %0d got y=%0d run=%0b exp y=%0d run=1", i, BirdY, run, exp_y[i]);
            end
        end
    endtask

    task automatic test_hold_key();
        logic [9:0] last_y;
        for (int i = 0; i < 19; i++) begin
            last_y = BirdY;
            frame((i < 10) ? 8'h1A : ((i < 14) ? 8'h2C : 8'h00), 1'b0, 1'b0);
            checks++;
            if (game_state !== 2'(m_state) || BirdY !== 10'(m_y) || score !== 8'(m_score) || run !== (m_state == 1)) begin
                errors++;
                $display("FAIL hold_key frame %0d got st=%0d y=%0d sc=%0d run=%0b exp st=%0d y=%0d sc=%0d", i, game_state, BirdY, score, run, m_state, m_y, m_score);
            end
        end
        checks += 2;
        if (BirdY !== 10'd222) begin errors++; $display("FAIL hold_key_final_y got %0d exp 222", BirdY); end
        if (BirdY - last_y !== 10'd8) begin errors++; $display("FAIL vel_cap_step got %0d exp 8", BirdY - last_y); end
    endtask

    task automatic test_free_fall();
        int n = 0;
        do_reset(8'h00);
        frame(8'h2C, 1'b0, 1'b0);
        while (game_state != 2'd3 && n < 200) begin
            frame(8'h00, 1'b0, 1'b0);
            checks++;
            if (game_state !== 2'(m_state) || BirdY !== 10'(m_y) || run !== (m_state == 1)) begin
                errors++;
                $display("FAIL free_fall frame %0d got st=%0d y=%0d run=%0b exp st=%0d y=%0d", n, game_state, BirdY, run, m_state, m_y);
            end
            n++;
        end
        checks += 4;
        if (game_state !== 2'd3) begin errors++; $display("FAIL free_fall_over got %0d exp 3", game_state); end
        if (BirdY !== 10'd463) begin errors++; $display("FAIL free_fall_ground got %0d exp 463", BirdY); end
        if (run !== 1'b0) begin errors++; $display("FAIL free_fall_run got %0b exp 0", run); end
        if (high_score !== 8'd0) begin errors++; $display("FAIL free_fall_high got %0d exp 0", high_score); end
        for (int i = 0; i < 3; i++) frame(8'h00, 1'b1, 1'b1);
        checks++;
        if (game_state !== 2'd3 || BirdY !== 10'd463 || score !== 8'd0) begin
            errors++;
            $display("FAIL over_hold got st=%0d y=%0d sc=%0d exp st=3 y=463 sc=0", game_state, BirdY, score);
        end
    endtask

    task automatic test_score_and_die();
        int n = 0;
        do_reset(8'h00);
        frame(8'h1A, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) frame(8'h00, 1'b0, (i % 2) == 0);
        frame(8'h00, 1'b1, 1'b1);
        checks += 2;
        if (score !== 8'd3) begin errors++; $display("FAIL hit_score got %0d exp 3", score); end
        if (game_state !== 2'd2 || run !== 1'b0) begin errors++; $display("FAIL hit_dying got st=%0d run=%0b exp st=2 run=0", game_state, run); end
        while (game_state != 2'd3 && n < 200) begin
            frame((n % 2) == 0 ? 8'h1A : 8'h00, n[2], n[1]);
            checks++;
            if (game_state !== 2'(m_state) || BirdY !== 10'(m_y) || score !== 8'd3 || run !== 1'b0) begin
                errors++;
                $display("FAIL dying_fall frame %0d got st=%0d y=%0d sc=%0d run=%0b exp st=%0d y=%0d sc=3", n, game_state, BirdY, score, run, m_state, m_y);
            end
            n++;
        end
        checks += 2;
        if (game_state !== 2'd3 || BirdY !== 10'd463) begin errors++; $display("FAIL dying_over got st=%0d y=%0d exp st=3 y=463", game_state, BirdY); end
        if (high_score !== 8'd3) begin errors++; $display("FAIL dying_high got %0d exp 3", high_score); end
    endtask

    task automatic test_ceiling();
        bit saw_top = 0;
        do_reset(8'h00);
        for (int i = 0; i < 60; i++) begin
            frame((i % 2) == 0 ? 8'h1A : 8'h00, 1'b0, 1'b0);
            if (BirdY == 10'd16) saw_top = 1;
            checks++;
            if (BirdY < 10'd16 || game_state !== 2'(m_state) || BirdY !== 10'(m_y)) begin
                errors++;
                $display("FAIL ceiling frame %0d got st=%0d y=%0d exp st=%0d y=%0d", i, game_state, BirdY, m_state, m_y);
            end
        end
        checks++;
        if (!saw_top) begin errors++; $display("FAIL ceiling_reached got 0 exp 1"); end
    endtask

    task automatic test_score_saturate();
        int n = 0;
        for (int i = 0; i < 270; i++) begin
            frame((i % 2) == 0 ? 8'h2C : 8'h00, 1'b0, 1'b1);
            checks++;
            if (score !== 8'(m_score) || BirdY !== 10'(m_y) || game_state !== 2'(m_state)) begin
                errors++;
                $display("FAIL saturate frame %0d got st=%0d y=%0d sc=%0d exp st=%0d y=%0d sc=%0d", i, game_state, BirdY, score, m_state, m_y, m_score);
            end
        end
        checks++;
        if (score !== 8'd255) begin errors++; $display("FAIL score_sat got %0d exp 255", score); end
        while (game_state != 2'd3 && n < 200) begin frame(8'h00, 1'b0, 1'b0); n++; end
        checks++;
        if (game_state !== 2'd3 || high_score !== 8'd255) begin
            errors++;
            $display("FAIL sat_high got st=%0d hi=%0d exp st=3 hi=255", game_state, high_score);
        end
    endtask

    task automatic test_back_to_back();
        frame(8'h1A, 1'b0, 1'b0);
        checks++;
        if (game_state !== 2'd0 || BirdY !== 10'd240 || score !== 8'd255) begin
            errors++;
            $display("FAIL over_to_idle got st=%0d y=%0d sc=%0d exp st=0 y=240 sc=255", game_state, BirdY, score);
        end
        frame(8'h1A, 1'b0, 1'b0);
        checks++;
        if (game_state !== 2'd0) begin errors++; $display("FAIL idle_held_key got %0d exp 0", game_state); end
        frame(8'h00, 1'b0, 1'b0);
        frame(8'h2C, 1'b0, 1'b0);
        checks++;
        if (game_state !== 2'd1 || score !== 8'd0 || high_score !== 8'd255 || run !== 1'b1) begin
            errors++;
            $display("FAIL replay got st=%0d sc=%0d hi=%0d run=%0b exp st=1 sc=0 hi=255 run=1", game_state, score, high_score, run);
        end
    endtask

    task automatic test_reset_mid_dying();
        do_reset(8'h00);
        frame(8'h1A, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) frame(8'h00, 1'b0, (i % 2) == 0);
        frame(8'h00, 1'b1, 1'b0);
        checks++;
        if (game_state !== 2'd2 || score !== 8'd5) begin
            errors++;
            $display("FAIL pre_reset got st=%0d sc=%0d exp st=2 sc=5", game_state, score);
        end
        do_reset(8'h1A);
        checks++;
        if (game_state !== 2'd0 || BirdY !== 10'd240 || score !== 8'd0 || high_score !== 8'd0 || run !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got st=%0d y=%0d sc=%0d hi=%0d run=%0b exp st=0 y=240 sc=0 hi=0 run=0", game_state, BirdY, score, high_score, run);
        end
        frame(8'h1A, 1'b0, 1'b0);
        checks++;
        if (game_state !== 2'd1) begin errors++; $display("FAIL flap_after_reset got %0d exp 1", game_state); end
    endtask

    task automatic test_random();
        logic [7:0] keys[4] = '{8'h00, 8'h1A, 8'h2C, 8'h04};
        int sel;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset(keys[$urandom_range(0, 3)]);
            end else begin
                sel = int'($urandom_range(0, 9));
                frame(sel < 5 ? keys[0] : (sel < 7 ? keys[1] : (sel < 9 ? keys[2] : keys[3])),
                      $urandom_range(0, 24) == 0, $urandom_range(0, 4) == 0);
            end
            checks++;
            if (game_state !== 2'(m_state) || BirdY !== 10'(m_y) || score !== 8'(m_score) ||
                high_score !== 8'(m_high) || run !== (m_state == 1)) begin
                errors++;
                $display("FAIL random frame %0d got st=%0d y=%0d sc=%0d hi=%0d run=%0b exp st=%0d y=%0d sc=%0d hi=%0d", i, game_state, BirdY, score, high_score, run, m_state, m_y, m_score, m_high);
            end
        end
    endtask

    initial begin
        Reset = 1'b1; keycode = 8'h00; pipe_hit = 1'b0; pipe_pass = 1'b0;
        model_reset();
        test_reset();
        test_first_flap();
        test_hold_key();
        test_free_fall();
        test_score_and_die();
        test_ceiling();
        test_score_saturate();
        test_back_to_back();
        test_reset_mid_dying();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
